// File: rtl/control_branch_unit.sv
// Main decoder, ALU-control decoder and branch/jump resolution for a single-issue RV32I core.
// Every output is combinational except ctrl_flow_q, which registers the redirect decision.
module control_branch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  Funct3,
  input  logic        Funct7,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic [31:0] PCAddr,
  input  logic [31:0] Result,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [2:0]  ALUOp,
  output logic [1:0]  SrcASel,
  output logic [1:0]  MemtoReg,
  output logic [4:0]  ALUCtrl,
  output logic        BranchTaken,
  output logic        JumpTaken,
  output logic [31:0] PC_Latched,
  output logic [31:0] JumpReturn,
  output logic        ctrl_flow_q
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b01010;
  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b01111;
  localparam logic [4:0] ALU_SLTU = 5'b11111;

  logic branch_d, mem_read_d, mem_write_d, reg_write_d;
  logic cond_met;
  logic unused_result_lsb;

  assign unused_result_lsb = Result[0];

  always_comb begin
    branch_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = 3'b000;
    SrcASel     = 2'b00;
    MemtoReg    = 2'b00;
    case (Opcode)
      OP_R:      begin reg_write_d = 1'b1; ALUOp = 3'b010; end
      OP_I:      begin reg_write_d = 1'b1; ALUSrc = 1'b1; ALUOp = 3'b011; end
      OP_LOAD:   begin reg_write_d = 1'b1; ALUSrc = 1'b1; mem_read_d = 1'b1; MemtoReg = 2'b01; end
      OP_STORE:  begin mem_write_d = 1'b1; ALUSrc = 1'b1; end
      OP_BRANCH: begin branch_d = 1'b1; ALUOp = 3'b001; end
      OP_JAL,
      OP_JALR:   begin reg_write_d = 1'b1; ALUSrc = 1'b1; MemtoReg = 2'b11; end
      OP_LUI:    begin reg_write_d = 1'b1; ALUSrc = 1'b1; SrcASel = 2'b01; end
      OP_AUIPC:  begin reg_write_d = 1'b1; ALUSrc = 1'b1; SrcASel = 2'b11; end
      default:   ;
    endcase
  end

  // Funct7 only distinguishes SUB from ADD for register-register ops; shifts use it in both forms.
  always_comb begin
    ALUCtrl = ALU_ADD;
    if (ALUOp == 3'b001) begin
      ALUCtrl = ALU_SUB;
    end else if (ALUOp == 3'b010 || ALUOp == 3'b011) begin
      case (Funct3)
        3'b000:  ALUCtrl = (ALUOp == 3'b010 && Funct7) ? ALU_SUB : ALU_ADD;
        3'b001:  ALUCtrl = ALU_SLL;
        3'b010:  ALUCtrl = ALU_SLT;
        3'b011:  ALUCtrl = ALU_SLTU;
        3'b100:  ALUCtrl = ALU_XOR;
        3'b101:  ALUCtrl = Funct7 ? ALU_SRA : ALU_SRL;
        3'b110:  ALUCtrl = ALU_OR;
        default: ALUCtrl = ALU_AND;
      endcase
    end
  end

  always_comb begin
    case (Funct3)
      3'b000:  cond_met = (RD1 == RD2);
      3'b001:  cond_met = (RD1 != RD2);
      3'b100:  cond_met = ($signed(RD1) <  $signed(RD2));
      3'b101:  cond_met = ($signed(RD1) >= $signed(RD2));
      3'b110:  cond_met = (RD1 <  RD2);
      3'b111:  cond_met = (RD1 >= RD2);
      default: cond_met = 1'b0;
    endcase
  end

  // Side-effecting controls are gated by reset so nothing commits while the core is held.
  assign Branch      = reset & branch_d;
  assign MemRead     = reset & mem_read_d;
  assign MemWrite    = reset & mem_write_d;
  assign RegWrite    = reset & reg_write_d;
  assign BranchTaken = reset & (((Opcode == OP_BRANCH) & cond_met) | (Opcode == OP_JAL));
  assign JumpTaken   = reset & (Opcode == OP_JALR);

  assign PC_Latched  = PCAddr + 32'd4;
  assign JumpReturn  = {Result[31:1], 1'b0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ctrl_flow_q <= 1'b0;
    else        ctrl_flow_q <= BranchTaken | JumpTaken;
  end

endmodule

// File: tb/tb_control_branch_unit.sv
// Self-checking bench for control_branch_unit: directed vectors plus randomized instructions
// compared against a table-driven reference model of the decode, ALU-control and branch rules.
module tb_control_branch_unit;

  logic        clock;
  logic        reset;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic        Funct7;
  logic [31:0] RD1, RD2, PCAddr, Result;
  logic        Branch, MemRead, MemWrite, ALUSrc, RegWrite;
  logic [2:0]  ALUOp;
  logic [1:0]  SrcASel, MemtoReg;
  logic [4:0]  ALUCtrl;
  logic        BranchTaken, JumpTaken;
  logic [31:0] PC_Latched, JumpReturn;
  logic        ctrl_flow_q;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        br, mr, mw, as, rw;
    logic [2:0]  aluop;
    logic [1:0]  srca, m2r;
    logic [4:0]  aluctrl;
    logic        bt, jt;
    logic [31:0] pcl, jr;
  } exp_t;

  control_branch_unit dut (
    .clock(clock), .reset(reset),
    .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
    .RD1(RD1), .RD2(RD2), .PCAddr(PCAddr), .Result(Result),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .SrcASel(SrcASel), .MemtoReg(MemtoReg), .ALUCtrl(ALUCtrl),
    .BranchTaken(BranchTaken), .JumpTaken(JumpTaken),
    .PC_Latched(PC_Latched), .JumpReturn(JumpReturn), .ctrl_flow_q(ctrl_flow_q)
  );

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: rows are Branch,MemRead,MemWrite,ALUSrc,RegWrite,ALUOp,SrcASel,MemtoReg
  function automatic logic [12:0] ctrl_row(input logic [6:0] op);
    case (op)
      7'b0110011: return 13'b0_0_0_0_1_010_00_00;
      7'b0010011: return 13'b0_0_0_1_1_011_00_00;
      7'b0000011: return 13'b0_1_0_1_1_000_00_01;
      7'b0100011: return 13'b0_0_1_1_0_000_00_00;
      7'b1100011: return 13'b1_0_0_0_0_001_00_00;
      7'b1101111: return 13'b0_0_0_1_1_000_00_11;
      7'b1100111: return 13'b0_0_0_1_1_000_00_11;
      7'b0110111: return 13'b0_0_0_1_1_000_01_00;
      7'b0010111: return 13'b0_0_0_1_1_000_11_00;
      default:    return 13'b0;
    endcase
  endfunction

  function automatic string alu_name(input logic [2:0] aluop, input logic [2:0] f3, input logic f7);
    if (aluop == 3'd1) return "SUB";
    if (aluop != 3'd2 && aluop != 3'd3) return "ADD";
    case (f3)
      3'd0: return (aluop == 3'd2 && f7) ? "SUB" : "ADD";
      3'd1: return "SLL";
      3'd2: return "SLT";
      3'd3: return "SLTU";
      3'd4: return "XOR";
      3'd5: return f7 ? "SRA" : "SRL";
      3'd6: return "OR";
      default: return "AND";
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input string n);
    if (n == "ADD")  return 5'b00010;
    if (n == "SUB")  return 5'b01010;
    if (n == "AND")  return 5'b00000;
    if (n == "OR")   return 5'b00001;
    if (n == "XOR")  return 5'b00011;
    if (n == "SLL")  return 5'b00100;
    if (n == "SRL")  return 5'b00101;
    if (n == "SRA")  return 5'b00110;
    if (n == "SLT")  return 5'b01111;
    return 5'b11111;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return {1'b0, a} < {1'b0, b};
      3'd7: return {1'b0, a} >= {1'b0, b};
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] res);
    exp_t e;
    logic [12:0] row;
    row = ctrl_row(op);
    {e.br, e.mr, e.mw, e.as, e.rw, e.aluop, e.srca, e.m2r} = row;
    e.aluctrl = alu_code(alu_name(e.aluop, f3, f7));
    e.bt  = (op == 7'b1100011 && branch_cond(f3, a, b)) || op == 7'b1101111;
    e.jt  = (op == 7'b1100111);
    e.pcl = 32'(64'(pc) + 64'd4);
    e.jr  = res & 32'hFFFF_FFFE;
    if (!rst) begin
      e.br = 0; e.mr = 0; e.mw = 0; e.rw = 0; e.bt = 0; e.jt = 0;
    end
    return e;
  endfunction

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    exp_t e;
    e = model(reset, Opcode, Funct3, Funct7, RD1, RD2, PCAddr, Result);
    chk({tag, "_Branch"},      32'(Branch),      32'(e.br));
    chk({tag, "_MemRead"},     32'(MemRead),     32'(e.mr));
    chk({tag, "_MemWrite"},    32'(MemWrite),    32'(e.mw));
    chk({tag, "_ALUSrc"},      32'(ALUSrc),      32'(e.as));
    chk({tag, "_RegWrite"},    32'(RegWrite),    32'(e.rw));
    chk({tag, "_ALUOp"},       32'(ALUOp),       32'(e.aluop));
    chk({tag, "_SrcASel"},     32'(SrcASel),     32'(e.srca));
    chk({tag, "_MemtoReg"},    32'(MemtoReg),    32'(e.m2r));
    chk({tag, "_ALUCtrl"},     32'(ALUCtrl),     32'(e.aluctrl));
    chk({tag, "_BranchTaken"}, 32'(BranchTaken), 32'(e.bt));
    chk({tag, "_JumpTaken"},   32'(JumpTaken),   32'(e.jt));
    chk({tag, "_PC_Latched"},  PC_Latched,       e.pcl);
    chk({tag, "_JumpReturn"},  JumpReturn,       e.jr);
  endtask

  // Driver: apply one instruction, check combinational outputs, then the registered flag.
  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] res);
    exp_t e;
    @(negedge clock);
    Opcode = op; Funct3 = f3; Funct7 = f7; RD1 = a; RD2 = b; PCAddr = pc; Result = res;
    #1;
    check_all(tag);
    e = model(reset, op, f3, f7, a, b, pc, res);
    @(posedge clock);
    #1;
    chk({tag, "_ctrl_flow_q"}, 32'(ctrl_flow_q), 32'(e.bt | e.jt));
  endtask

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    reset = 1'b0;
    Opcode = 7'b0100011; Funct3 = 3'd0; Funct7 = 1'b0;
    RD1 = 32'd0; RD2 = 32'd0; PCAddr = 32'd0; Result = 32'd0;
    #3;
    chk("reset_ctrl_flow_q", 32'(ctrl_flow_q), 32'd0);
    chk("reset_MemWrite", 32'(MemWrite), 32'd0);
    chk("reset_ALUSrc_kept", 32'(ALUSrc), 32'd1);
    step("reset_store", 7'b0100011, 3'd2, 1'b0, 32'h1, 32'h2, 32'h40, 32'h80);
    @(negedge clock);
    reset = 1'b1;

    step("r_sub", 7'b0110011, 3'd0, 1'b1, 32'd9, 32'd3, 32'h10, 32'h6);
    chk("r_sub_ALUCtrl_lit", 32'(ALUCtrl), 32'b01010);
    chk("r_sub_RegWrite_lit", 32'(RegWrite), 32'd1);

    step("blt", 7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h0);
    chk("blt_taken_lit", 32'(BranchTaken), 32'd1);
    step("bltu", 7'b1100011, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h0);
    chk("bltu_taken_lit", 32'(BranchTaken), 32'd0);

    step("jalr", 7'b1100111, 3'd0, 1'b0, 32'h0, 32'h0, 32'h100, 32'h203);
    chk("jalr_JumpReturn_lit", JumpReturn, 32'h202);
    chk("jalr_PC_Latched_lit", PC_Latched, 32'h104);
    chk("jalr_flow_lit", 32'(ctrl_flow_q), 32'd1);

    step("addi_f7", 7'b0010011, 3'd0, 1'b1, 32'h5, 32'h0, 32'h0, 32'h0);
    chk("addi_ALUCtrl_lit", 32'(ALUCtrl), 32'b00010);
    step("srai", 7'b0010011, 3'd5, 1'b1, 32'h5, 32'h0, 32'h0, 32'h0);
    chk("srai_ALUCtrl_lit", 32'(ALUCtrl), 32'b00110);

    step("store", 7'b0100011, 3'd2, 1'b0, 32'h5, 32'h6, 32'h8, 32'hC);
    step("unknown_wrap", 7'b1111111, 3'd3, 1'b1, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h7);
    chk("wrap_PC_Latched_lit", PC_Latched, 32'h0);
    chk("unknown_ALUCtrl_lit", 32'(ALUCtrl), 32'b00010);

    // Reset asserted mid-cycle after a taken jump must clear the flag and the redirect at once.
    step("jal_pre", 7'b1101111, 3'd0, 1'b0, 32'h0, 32'h0, 32'h200, 32'h0);
    chk("jal_pre_flow_lit", 32'(ctrl_flow_q), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_flow_async", 32'(ctrl_flow_q), 32'd0);
    chk("midrst_BranchTaken", 32'(BranchTaken), 32'd0);
    check_all("midrst");
    @(posedge clock); #1;
    chk("midrst_flow_hold", 32'(ctrl_flow_q), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("release_BranchTaken", 32'(BranchTaken), 32'd1);
    chk("release_flow_still0", 32'(ctrl_flow_q), 32'd0);
    @(posedge clock); #1;
    chk("release_flow_edge", 32'(ctrl_flow_q), 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : OPS[$urandom_range(0, 8)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step("rand", op, 3'($urandom), 1'($urandom), a, b, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_branch_unit.md
CONTROL_BRANCH_UNIT -- requirements
Module: control_branch_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
REQ-002 The module SHALL have these inputs:
- Opcode  in  7  Ins[6:0]
- Funct3  in  3  Ins[14:12]
- Funct7  in  1  Ins[30]
- RD1, RD2  in  32  register-file read data
- PCAddr  in  32  current PC
- Result  in  32  ALU result
REQ-003 The module SHALL have these control outputs:
- Branch, MemRead, MemWrite, ALUSrc, RegWrite  out  1  datapath controls
- ALUOp  out  3  ALU operation class
- SrcASel  out  2  ALU A source: 00 RD1, 01 zero, 11 PC
- MemtoReg  out  2  write-back source: 00 Result, 01 ReadData, 11 PC_Latched
REQ-004 The module SHALL have these ALU-control outputs:
- ALUCtrl  out  5  [4] Ainv/unsigned, [3] Binv, [2:0] ALUsel
REQ-005 The module SHALL have these branch outputs:
- BranchTaken  out  1  select external PC+imm target
- JumpTaken  out  1  select JumpReturn
- PC_Latched  out  32  link value
- JumpReturn  out  32  JALR target
- ctrl_flow_q  out  1  registered redirect flag

Function
REQ-006 All outputs except ctrl_flow_q SHALL be combinational, with zero-cycle latency.
REQ-007 Decode per opcode SHALL be, with fields listed as Branch, MemRead, MemWrite, ALUSrc, RegWrite, ALUOp, SrcASel, MemtoReg:
- R 0110011: 0,0,0,0,1,010,00,00
- I-ALU 0010011: 0,0,0,1,1,011,00,00
- LOAD 0000011: 0,1,0,1,1,000,00,01
- STORE 0100011: 0,0,1,1,0,000,00,00
- BRANCH 1100011: 1,0,0,0,0,001,00,00
- JAL 1101111: 0,0,0,1,1,000,00,11
- JALR 1100111: 0,0,0,1,1,000,00,11
- LUI 0110111: 0,0,0,1,1,000,01,00
- AUIPC 0010111: 0,0,0,1,1,000,11,00
REQ-008 Any other opcode SHALL produce all-zero control outputs, with ALUOp=000.
REQ-009 ALUCtrl codes SHALL be:
- ADD 00010, SUB 01010
- AND 00000, OR 00001, XOR 00011
- SLL 00100, SRL 00101, SRA 00110
- SLT 01111, SLTU 11111
REQ-010 ALUOp 000, 100, 101, 110 and 111 SHALL produce ADD.
REQ-011 ALUOp 001 SHALL produce SUB.
REQ-012 ALUOp 010 (R-type) SHALL map Funct3 as follows:
- 000: ADD if Funct7=0, else SUB
- 001 SLL, 010 SLT, 011 SLTU, 100 XOR
- 101: SRL if Funct7=0, else SRA
- 110 OR, 111 AND
REQ-013 ALUOp 011 (I-type) SHALL use the R-type mapping, except that Funct3=000 is always ADD (Funct7 ignored); Funct3=101 still uses Funct7.
REQ-014 For BRANCH, taken SHALL be evaluated on RD1 vs RD2:
- 000 BEQ, 001 BNE
- 100 BLT signed, 101 BGE signed
- 110 BLTU unsigned, 111 BGEU unsigned
- 010/011: never taken
REQ-015 BranchTaken SHALL be 1 when (Opcode=BRANCH and the condition holds) or Opcode=JAL; otherwise 0.
REQ-016 JumpTaken SHALL be 1 only when Opcode=JALR.
REQ-017 BranchTaken and JumpTaken SHALL never both be 1.
REQ-018 JumpReturn SHALL equal {Result[31:1],1'b0} for every opcode.
REQ-019 PC_Latched SHALL equal PCAddr+4 modulo 2^32 for every opcode, so that 0xFFFFFFFC yields 0x00000000.
REQ-020 On each rising clock edge, ctrl_flow_q SHALL load (BranchTaken | JumpTaken).

Reset
REQ-021 While reset=0, these outputs SHALL be forced to 0 asynchronously, regardless of inputs: RegWrite, MemWrite, MemRead, Branch, BranchTaken, JumpTaken.
REQ-022 While reset=0, ctrl_flow_q SHALL clear to 0 immediately and hold 0.
REQ-023 While reset=0, all other outputs SHALL keep their normal decoded values.
REQ-024 Reset deassertion SHALL take effect combinationally; ctrl_flow_q SHALL first update at the next rising edge.
REQ-025 Reset asserted mid-operation SHALL suppress any pending redirect in the same cycle.

Verification
REQ-026 R-type SUB, Opcode=0110011, Funct3=000, Funct7=1 -> ALUCtrl=01010, ALUOp=010, RegWrite=1, ALUSrc=0, MemtoReg=00.
REQ-027 BLT, RD1=0xFFFFFFFF, RD2=0x00000001 -> BranchTaken=1; BLTU with the same operands -> BranchTaken=0.
REQ-028 JALR, PCAddr=0x00000100, Result=0x00000203 -> JumpTaken=1, JumpReturn=0x00000202, PC_Latched=0x00000104, MemtoReg=11, then ctrl_flow_q=1 after the next edge.
REQ-029 ADDI, Opcode=0010011, Funct3=000, Funct7=1 -> ALUCtrl=00010 (ADD, not SUB); SRAI with Funct3=101, Funct7=1 -> 00110.
REQ-030 Store, Opcode=0100011 -> MemWrite=1, RegWrite=0, ALUSrc=1; with reset=0 -> MemWrite=0 and ctrl_flow_q=0.
REQ-031 Unknown Opcode=1111111 -> all controls 0, ALUCtrl=00010; PCAddr=0xFFFFFFFC -> PC_Latched=0x00000000.
